// File: rtl/arm_ctrl_pkg.sv
// ============================================================================
// Module   : arm_ctrl_pkg
// Brief    : Shared state encoding, ALU op codes and DP cmd codes for the
//            multicycle ARM control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    // Funct[4:1] data-processing command codes
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    function automatic logic [1:0] immSrcOf(input logic [1:0] op);
        case (op)
            OP_MEM:  return 2'b01;
            OP_BR:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/arm_alu_decoder.sv
// ============================================================================
// Module   : arm_alu_decoder
// Brief    : Combinational decode of the DP cmd field into ALU op, flag write
//            enables, compare-only suppression and an unsupported-cmd flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arm_alu_decoder
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_W = 3
) (
    input  logic [3:0]       cmd,
    input  logic             S,
    input  logic             aluOpEn,
    output logic [ALU_W-1:0] ALUControl,
    output logic [1:0]       FlagW,
    output logic             NoWrite,
    output logic             badCmd
);

    logic [2:0] w_op;
    logic       w_arith;
    logic       w_noWrite;
    logic       w_bad;

    always_comb begin
        w_op      = ALU_ADD;
        w_arith   = 1'b0;
        w_noWrite = 1'b0;
        w_bad     = 1'b0;
        case (cmd)
            CMD_ADD: begin w_op = ALU_ADD; w_arith = 1'b1; end
            CMD_SUB: begin w_op = ALU_SUB; w_arith = 1'b1; end
            CMD_AND: w_op = ALU_AND;
            CMD_ORR: w_op = ALU_ORR;
            CMD_EOR: w_op = ALU_EOR;
            CMD_MOV: w_op = ALU_MOV;
            CMD_CMP: begin w_op = ALU_SUB; w_arith = 1'b1; w_noWrite = 1'b1; end
            default: w_bad = 1'b1;
        endcase
    end

    // Outside the ALU states everything collapses to a plain ADD with no side effects
    assign ALUControl = aluOpEn ? ALU_W'(w_op) : ALU_W'(ALU_ADD);
    assign FlagW      = aluOpEn ? {S, S & w_arith} : 2'b00;
    assign NoWrite    = aluOpEn & w_noWrite;
    assign badCmd     = aluOpEn & w_bad;

endmodule

`default_nettype wire

// File: rtl/arm_multicycle_ctrl.sv
// ============================================================================
// Module   : arm_multicycle_ctrl
// Brief    : Multicycle ARM control FSM with memory wait handshake. Define
//            ARM_CTRL_PERF_CNT_EN to build the retired-instruction/cycle counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_W = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             PCS,
    output logic [ALU_W-1:0] ALUControl,
    output logic [1:0]       FlagW,
    output logic             NoWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    state_t r_state;
    state_t w_nextState;
    logic   w_inExec;
    logic   w_aluOpEn;
    logic   w_badCmd;
    logic   w_noWrite;
    logic [1:0] w_flagW;

    assign w_inExec  = (r_state == EXECR) || (r_state == EXECI);
    assign w_aluOpEn = !reset && (w_inExec || (r_state == ALUWB));

    arm_alu_decoder #(.ALU_W(ALU_W)) u_aluDec (
        .cmd        (Funct[4:1]),
        .S          (Funct[0]),
        .aluOpEn    (w_aluOpEn),
        .ALUControl (ALUControl),
        .FlagW      (w_flagW),
        .NoWrite    (w_noWrite),
        .badCmd     (w_badCmd)
    );

    assign NoWrite = w_noWrite;

    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FETCH:  if (mem_ready) w_nextState = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  w_nextState = MEMADR;
                    OP_DP:   w_nextState = Funct[5] ? EXECI : EXECR;
                    OP_BR:   w_nextState = BRANCH;
                    default: w_nextState = FETCH;
                endcase
            end
            MEMADR: w_nextState = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) w_nextState = MEMWB;
            MEMWR:  if (mem_ready) w_nextState = FETCH;
            EXECR,
            EXECI:  w_nextState = ALUWB;
            MEMWB,
            ALUWB,
            BRANCH: w_nextState = FETCH;
            default: w_nextState = FETCH;
        endcase
    end

    // Reset overrides every enable and select so an abandoned instruction writes nothing
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ImmSrc    = 2'b00;
        RegSrc    = 2'b00;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        PCS       = 1'b0;
        FlagW     = 2'b00;
        illegal   = 1'b0;
        if (!reset) begin
            ImmSrc = immSrcOf(Op);
            RegSrc = {Op == OP_MEM, Op == OP_BR};
            case (r_state)
                FETCH: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    NextPC    = mem_ready;
                end
                DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    illegal = (Op == OP_BAD);
                end
                MEMADR: ALUSrcB = 2'b01;
                MEMRD:  AdrSrc  = 1'b1;
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                    PCS       = (Rd == 4'hF);
                end
                MEMWR: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                EXECR,
                EXECI: begin
                    ALUSrcB = (r_state == EXECI) ? 2'b01 : 2'b00;
                    FlagW   = w_flagW;
                    illegal = w_badCmd;
                end
                ALUWB: begin
                    RegW = !w_noWrite;
                    PCS  = (Rd == 4'hF) && !w_noWrite;
                end
                BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                    PCS       = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ARM_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_instrCount;
    logic [CNT_W-1:0] r_cycleCount;
    logic             w_retire;

    assign w_retire = (w_nextState == FETCH) &&
                      ((r_state == MEMWB) || (r_state == MEMWR) ||
                       (r_state == ALUWB) || (r_state == BRANCH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instrCount <= '0;
            r_cycleCount <= '0;
        end else begin
            r_cycleCount <= r_cycleCount + 1'b1;
            if (w_retire) r_instrCount <= r_instrCount + 1'b1;
        end
    end

    assign instr_count = r_instrCount;
    assign cycle_count = r_cycleCount;
`else
    assign instr_count = '0;
    assign cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arm_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_arm_multicycle_ctrl
// Brief    : Randomized self-checking bench; expected per-cycle outputs are
//            built from instruction class, wait counts and the cmd table.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_arm_multicycle_ctrl;

    localparam int ALU_W = 3;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       Op = 2'b00;
    logic [5:0]       Funct = 6'd0;
    logic [3:0]       Rd = 4'd0;
    logic             mem_ready = 1'b0;
    logic             IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, PCS, NoWrite, illegal;
    logic [1:0]       ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
    logic [ALU_W-1:0] ALUControl;
    logic [CNT_W-1:0] instr_count, cycle_count;

    always #5 clk = ~clk;

    arm_multicycle_ctrl #(.ALU_W(ALU_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .RegW(RegW), .MemW(MemW), .Branch(Branch), .PCS(PCS), .ALUControl(ALUControl),
        .FlagW(FlagW), .NoWrite(NoWrite), .illegal(illegal),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    typedef struct packed {
        logic       IRWrite, NextPC, AdrSrc;
        logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
        logic       RegW, MemW, Branch, PCS;
        logic [2:0] ALUControl;
        logic [1:0] FlagW;
        logic       NoWrite, illegal;
    } outs_t;

    outs_t       expQ[$];
    bit          rdyQ[$];
    int          nChecks = 0;
    int          nFail = 0;
    int unsigned mCycle = 0;
    int unsigned mInstr = 0;

    // cmd table: ALU op, supported, compare-only, arithmetic (writes C/V)
    logic [2:0] aluOp[16];
    bit         aluOk[16];
    bit         aluNw[16];
    bit         aluAr[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic outs_t observed();
        outs_t o;
        o.IRWrite = IRWrite;  o.NextPC = NextPC;    o.AdrSrc = AdrSrc;
        o.ALUSrcA = ALUSrcA;  o.ALUSrcB = ALUSrcB;  o.ResultSrc = ResultSrc;
        o.ImmSrc = ImmSrc;    o.RegSrc = RegSrc;    o.RegW = RegW;
        o.MemW = MemW;        o.Branch = Branch;    o.PCS = PCS;
        o.ALUControl = ALUControl; o.FlagW = FlagW; o.NoWrite = NoWrite;
        o.illegal = illegal;
        return o;
    endfunction

    function automatic outs_t baseOuts(input logic [1:0] op);
        outs_t o = '0;
        o.ImmSrc = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        o.RegSrc = {op == 2'b01, op == 2'b10};
        return o;
    endfunction

    task automatic push(input outs_t o, input bit rdy);
        expQ.push_back(o);
        rdyQ.push_back(rdy);
    endtask

    task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                         input int fw, input int mw);
        outs_t o;
        logic [3:0] cmd = funct[4:1];
        logic       s = funct[0];
        logic [2:0] aluc;
        o = baseOuts(op); o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b10; o.ResultSrc = 2'b10;
        for (int k = 0; k < fw; k++) push(o, 1'b0);
        o.IRWrite = 1'b1; o.NextPC = 1'b1;
        push(o, 1'b1);
        o = baseOuts(op); o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b10; o.illegal = (op == 2'b11);
        push(o, 1'($urandom));
        if (op == 2'b01) begin
            o = baseOuts(op); o.ALUSrcB = 2'b01;
            push(o, 1'($urandom));
            o = baseOuts(op); o.AdrSrc = 1'b1; o.MemW = !funct[0];
            for (int k = 0; k < mw; k++) push(o, 1'b0);
            push(o, 1'b1);
            if (funct[0]) begin
                o = baseOuts(op); o.ResultSrc = 2'b01; o.RegW = 1'b1; o.PCS = (rd == 4'hF);
                push(o, 1'($urandom));
            end
        end else if (op == 2'b10) begin
            o = baseOuts(op); o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b01; o.ResultSrc = 2'b10;
            o.Branch = 1'b1; o.PCS = 1'b1;
            push(o, 1'($urandom));
        end else if (op == 2'b00) begin
            aluc = aluOk[cmd] ? aluOp[cmd] : 3'b000;
            o = baseOuts(op); o.ALUSrcB = funct[5] ? 2'b01 : 2'b00; o.ALUControl = aluc;
            o.FlagW = {s, s & aluAr[cmd]}; o.NoWrite = aluNw[cmd]; o.illegal = !aluOk[cmd];
            push(o, 1'($urandom));
            o = baseOuts(op); o.ALUControl = aluc; o.NoWrite = aluNw[cmd];
            o.RegW = !aluNw[cmd]; o.PCS = (rd == 4'hF) && !aluNw[cmd];
            push(o, 1'($urandom));
        end
    endtask

    task automatic checkCounters(input string tag);
`ifdef ARM_CTRL_PERF_CNT_EN
        check({tag, "/cnt"}, {32'(instr_count), 32'(cycle_count)}, {mInstr, mCycle});
`else
        check({tag, "/cnt"}, {32'(instr_count), 32'(cycle_count)}, 64'd0);
`endif
    endtask

    // abortAt >= 0 raises reset on that step and abandons the instruction
    task automatic runInstr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                            input logic [3:0] rd, input int fw, input int mw, input int abortAt);
        expQ.delete();
        rdyQ.delete();
        build(op, funct, rd, fw, mw);
        for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clk);
            reset = (i == abortAt);
            Op = op; Funct = funct; Rd = rd; mem_ready = rdyQ[i];
            #1;
            if (i == abortAt)
                check($sformatf("%s/rst%0d", tag, i), 64'(observed()), 64'd0);
            else
                check($sformatf("%s/s%0d", tag, i), 64'(observed()), 64'(expQ[i]));
            checkCounters($sformatf("%s/s%0d", tag, i));
            @(posedge clk);
            if (i == abortAt) begin
                mCycle = 0;
                mInstr = 0;
                return;
            end
            mCycle++;
        end
        if (op != 2'b11) mInstr++;
    endtask

    initial begin
        for (int c = 0; c < 16; c++) begin
            aluOp[c] = 3'b000; aluOk[c] = 1'b0; aluNw[c] = 1'b0; aluAr[c] = 1'b0;
        end
        aluOp[4'b0100] = 3'b000; aluOk[4'b0100] = 1'b1; aluAr[4'b0100] = 1'b1;
        aluOp[4'b0010] = 3'b001; aluOk[4'b0010] = 1'b1; aluAr[4'b0010] = 1'b1;
        aluOp[4'b0000] = 3'b010; aluOk[4'b0000] = 1'b1;
        aluOp[4'b1100] = 3'b011; aluOk[4'b1100] = 1'b1;
        aluOp[4'b0001] = 3'b100; aluOk[4'b0001] = 1'b1;
        aluOp[4'b1101] = 3'b101; aluOk[4'b1101] = 1'b1;
        aluOp[4'b1010] = 3'b001; aluOk[4'b1010] = 1'b1; aluAr[4'b1010] = 1'b1; aluNw[4'b1010] = 1'b1;

        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            Op = 2'($urandom); Funct = 6'($urandom); Rd = 4'($urandom);
            mem_ready = 1'($urandom);
            #1;
            check("reset", 64'(observed()), 64'd0);
            @(posedge clk);
        end
        mCycle = 0;
        mInstr = 0;

        runInstr("add",    2'b00, 6'b001000, 4'd1,  0, 0, -1);
        runInstr("ldr",    2'b01, 6'b011001, 4'd2,  0, 2, -1);
        runInstr("str",    2'b01, 6'b011000, 4'd3,  0, 1, -1);
        runInstr("cmp",    2'b00, 6'b010101, 4'd0,  0, 0, -1);
        runInstr("movpc",  2'b00, 6'b111010, 4'hF,  0, 0, -1);
        runInstr("undef",  2'b11, 6'b000000, 4'd0,  0, 0, -1);
        runInstr("b",      2'b10, 6'b101010, 4'd0,  1, 0, -1);
        runInstr("ldrpc",  2'b01, 6'b011001, 4'hF,  2, 0, -1);
        runInstr("strrst", 2'b01, 6'b011000, 4'd4,  0, 3,  4);
        runInstr("after",  2'b00, 6'b001000, 4'd5,  0, 0, -1);

        for (int n = 0; n < 200; n++) begin
            logic [1:0] op;
            int         cls = $urandom_range(0, 9);
            op = (cls < 4) ? 2'b00 : (cls < 7) ? 2'b01 : (cls < 9) ? 2'b10 : 2'b11;
            runInstr($sformatf("rnd%0d", n), op, 6'($urandom), 4'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 2),
                     ($urandom_range(0, 24) == 0) ? 1 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

`default_nettype wire
